mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 33 +++
 rtl/mem_access_ctrl_ld_lane_ext.sv | 32 +++
 rtl/mem_access_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access controller: op_type encodings,
// FSM state encoding, the load poison value, and op legality/alignment helpers.
package mem_access_ctrl_pkg;

  localparam logic [2:0] OP_WORD = 3'b111;
  localparam logic [2:0] OP_BU   = 3'b001;
  localparam logic [2:0] OP_BS   = 3'b010;
  localparam logic [2:0] OP_HU   = 3'b011;
  localparam logic [2:0] OP_HS   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returned on ld_data when the bus watchdog aborts a transaction.
  localparam logic [31:0] LD_POISON = 32'hdddd_dddd;

  function automatic logic op_legal(input logic [2:0] t);
    return (t == OP_WORD) || (t == OP_BU) || (t == OP_BS) ||
           (t == OP_HU) || (t == OP_HS);
  endfunction

  function automatic logic op_aligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      OP_WORD:      return (a == 2'b00);
      OP_HU, OP_HS: return !a[0];
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_ld_lane_ext.sv
// ld_lane_ext: picks the byte/half lane out of a bus read word and
// zero- or sign-extends it according to op_type. Purely combinational.
module ld_lane_ext (
  input  logic [2:0]  op_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  import mem_access_ctrl_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extension; words pass through untouched.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_type_i)
      OP_BU:   data_o = {24'b0, byte_sel};
      OP_BS:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_HU:   data_o = {16'b0, half_sel};
      OP_HS:   data_o = {{16{half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller turning load/store ops into single
// bus transactions (IDLE -> BUSY -> DONE), with alignment exceptions, lane
// steering, flush handling and load extraction via ld_lane_ext.
// Optional feature: define DM_TIMEOUT_EN to enable the bus-ack watchdog
// (TIMEOUT_CYCLES); without it BUSY waits forever and bus_err is tied low.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);
  import mem_access_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  type_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        kill_q, kill_d;
  logic        err_q;
  logic [31:0] ld_data_q;
  logic        accept, capture, timeout;
  logic        wd_expired;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ext_data;

  // Steer incoming store data onto byte lanes; latched on accept.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = op_wdata;
    case (op_type)
      OP_HU, OP_HS: begin
        lane_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{op_wdata[15:0]}};
      end
      OP_BU, OP_BS: begin
        lane_be    = 4'b0001 << op_addr[1:0];
        lane_wdata = {4{op_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  ld_lane_ext u_ld_lane_ext (
    .op_type_i (type_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (bus_rdata),
    .data_o    (ext_data)
  );

`ifdef DM_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  assign wd_expired = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign bus_err    = (state_q == ST_DONE) && err_q;

  // Watchdog counts consecutive BUSY cycles; cleared whenever BUSY is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if ((state_q == ST_BUSY) && (state_d == ST_BUSY)) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign wd_expired     = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // Next-state and outputs; bus outputs are only driven while BUSY.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    stall     = 1'b0;
    ld_valid  = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush && op_legal(op_type)) begin
          if (op_aligned(op_type, op_addr[1:0])) begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            exc_adel = !op_we;
            exc_ades = op_we;
          end
        end
      end
      ST_BUSY: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_q;
        bus_wdata = wdata_q;
        if (flush) kill_d = 1'b1;
        if (bus_ack) begin
          capture = 1'b1;
          kill_d  = 1'b0;
          // A killed op still finishes on the bus but skips DONE.
          state_d = (kill_q || flush) ? ST_IDLE : ST_DONE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          kill_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ld_valid = !we_q && !flush && !err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and sticky kill flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Latch the accepted op so the bus sees stable values throughout BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= op_addr;
      type_q  <= op_type;
      we_q    <= op_we;
      be_q    <= lane_be;
      wdata_q <= lane_wdata;
    end
  end

  // Capture the extracted load result, or poison it on a watchdog abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else if (capture) begin
      ld_data_q <= ext_data;
      err_q     <= 1'b0;
    end else if (timeout) begin
      ld_data_q <= LD_POISON;
      err_q     <= 1'b1;
    end
  end

  assign ld_data = ld_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues ops and pushes the
// expected bus transaction / load result / exception into queues computed
// from a byte-addressed reference memory; a monitor pops and compares.
// Define DM_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_mem_access_ctrl;

`ifdef DM_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_we, flush;
  logic [2:0]  op_type;
  logic [31:0] op_addr, op_wdata;
  logic        stall, ld_valid, exc_adel, exc_ades;
  logic [31:0] ld_data;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_we(op_we),
    .op_type(op_type), .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  typedef struct { int kind; logic [31:0] data; } resp_t;  // 1 adel, 2 ades, 3 load
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

  resp_t      resp_q[$];
  bus_t       bus_q[$];
  logic [7:0] ref_mem [1024];
  logic [31:0] bus_mem [256];
  int         ack_delay_next = 0;
  bit         spurious_en = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=no_event", name);
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    bus_mem[addr[9:2]] = val;
    for (int k = 0; k < 4; k++) ref_mem[{addr[9:2], 2'b00} + k] = val[8*k +: 8];
  endtask

  // Memory responder: acks the (d+1)-th BUSY cycle; injects stray acks when idle.
  initial begin : responder
    int wait_cnt;
    bit in_txn;
    wait_cnt = 0;
    in_txn = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        if (!in_txn) begin
          in_txn = 1;
          wait_cnt = ack_delay_next;
        end
        if (wait_cnt == 0) begin
          bus_ack = 1'b1;
          in_txn = 0;
          if (bus_we) begin
            for (int i = 0; i < 4; i++)
              if (bus_be[i]) bus_mem[bus_addr[9:2]][8*i +: 8] = bus_wdata[8*i +: 8];
          end else begin
            bus_rdata = bus_mem[bus_addr[9:2]];
          end
        end else begin
          wait_cnt--;
        end
      end else begin
        in_txn = 0;
        if (spurious_en && $urandom_range(0, 3) == 0) bus_ack = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin : monitor
    bit prev_ack;
    bit prev_req;
    bus_t cur;
    resp_t r;
    prev_ack = 0;
    prev_req = 0;
    cur = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exc_adel || exc_ades) begin
          chk("exc_both", {31'b0, exc_adel & exc_ades}, 32'd0);
          if (resp_q.size() == 0) note_fail("unexpected_exc");
          else begin
            r = resp_q.pop_front();
            chk("exc_kind", exc_adel ? 32'd1 : 32'd2, r.kind);
          end
        end
        if (ld_valid) begin
          chk("ld_timing", {31'b0, prev_ack}, 32'd1);
          if (resp_q.size() == 0) note_fail("unexpected_ld_valid");
          else begin
            r = resp_q.pop_front();
            chk("resp_kind_ld", 32'd3, r.kind);
            chk("ld_data", ld_data, r.data);
          end
        end
        if (bus_req && !prev_req) begin
          if (bus_q.size() == 0) note_fail("unexpected_bus_req");
          else cur = bus_q.pop_front();
        end
        if (bus_req) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
          if (cur.we) begin
            chk("bus_be", {28'b0, bus_be}, {28'b0, cur.be});
            chk("bus_wdata", bus_wdata, cur.wdata);
          end
        end
        if (prev_ack) begin
          chk("stall_release", {31'b0, stall}, 32'd0);
          chk("req_release", {31'b0, bus_req}, 32'd0);
        end
`ifndef DM_TIMEOUT_EN
        chk("bus_err_low", {31'b0, bus_err}, 32'd0);
`endif
        prev_ack = bus_req && bus_ack;
        prev_req = bus_req;
      end else begin
        prev_ack = 0;
        prev_req = 0;
      end
    end
  end

  // Issue one op; fmode 0 = none, 1 = flush in first BUSY cycle, 2 = flush in DONE.
  task automatic do_op(input logic we, input logic [2:0] t, input logic [31:0] addr,
                       input logic [31:0] wd, input int d, input int fmode);
    int size, sc, n;
    bit legal, aligned, s;
    longint v;
    resp_t r;
    bus_t b;
    legal = t inside {3'b111, 3'b001, 3'b010, 3'b011, 3'b100};
    size = (t == 3'b111) ? 4 : ((t == 3'b011 || t == 3'b100) ? 2 : 1);
    aligned = (addr % size) == 0;
    if (legal && !aligned) begin
      r.kind = we ? 2 : 1;
      r.data = '0;
      resp_q.push_back(r);
    end
    if (legal && aligned) begin
      b.addr = addr & ~32'h3;
      b.we = we;
      b.be = '0;
      b.wdata = '0;
      for (int k = 0; k < size; k++) b.be[(addr % 4) + k] = 1'b1;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      bus_q.push_back(b);
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[(addr + k) % 1024] = wd[8*k +: 8];
      end else if (fmode == 0) begin
        v = 0;
        for (int k = 0; k < size; k++) v = v | (longint'(ref_mem[(addr + k) % 1024]) << (8*k));
        if ((t == 3'b010 || t == 3'b100) && v >= (longint'(1) << (8*size - 1)))
          v = v - (longint'(1) << (8*size));
        r.kind = 3;
        r.data = v[31:0];
        resp_q.push_back(r);
      end
    end
    ack_delay_next = d;
    op_valid = 1'b1;
    op_we = we;
    op_type = t;
    op_addr = addr;
    op_wdata = wd;
    $display("op we=%0d type=%03b addr=%08h wdata=%08h delay=%0d flush_mode=%0d",
             we, t, addr, wd, d, fmode);
    sc = 0;
    n = 0;
    forever begin
      @(negedge clk);
      s = stall;
      if (s) sc++;
      @(posedge clk); #1;
      flush = 1'b0;
      n++;
      if (!s) break;
      if (n > 60) begin
        note_fail("op_cycle_bound");
        break;
      end
      if (n == 1 && fmode == 1) begin
        flush = 1'b1;
        op_valid = 1'b0;
      end else if (fmode == 2 && stall == 1'b0) begin
        flush = 1'b1;
      end
    end
    chk("stall_cycles", sc, (legal && aligned) ? 2 + d : 0);
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [2:0] pick_type(input int r);
    case (r)
      0, 5:    return 3'b111;
      1:       return 3'b001;
      2, 6:    return 3'b010;
      3:       return 3'b011;
      4, 7:    return 3'b100;
      8:       return 3'b000;
      9:       return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    bus_t b;
    int fr;
    reset = 1'b1;
    op_valid = 1'b0;
    op_we = 1'b0;
    op_type = '0;
    op_addr = '0;
    op_wdata = '0;
    flush = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 256; w++)
      bus_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ld_valid", {31'b0, ld_valid}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_exc_adel", {31'b0, exc_adel}, 32'd0);
    chk("rst_exc_ades", {31'b0, exc_ades}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    reset = 1'b0;

    // Directed cases
    set_word(32'h100, 32'h80FF_FF00);
    do_op(1'b0, 3'b010, 32'h0000_0103, 32'h0, 1, 0);          // lb, sign-extended 0x80
    do_op(1'b1, 3'b011, 32'h0000_0202, 32'h0000_BEEF, 0, 0);  // sh, upper half
    do_op(1'b0, 3'b111, 32'h0000_0101, 32'h0, 0, 0);          // misaligned lw
    do_op(1'b0, 3'b011, 32'h0000_0204, 32'h0, 3, 1);          // lhu flushed in BUSY
    do_op(1'b1, 3'b101, 32'h0000_0208, 32'h1234_5678, 0, 0);  // illegal op_type
    do_op(1'b0, 3'b111, 32'h0000_0100, 32'h0, 2, 2);          // lw flushed in DONE
    do_op(1'b0, 3'b001, 32'h0000_0202, 32'h0, 0, 0);          // lbu back-to-back
    do_op(1'b1, 3'b001, 32'h0000_0103, 32'h0000_00A5, 0, 0);  // sb top lane
    do_op(1'b0, 3'b111, 32'h0000_0100, 32'h0, 0, 0);          // lw sees the sb

    // Reset in the middle of BUSY
    b.addr = 32'h300; b.we = 1'b0; b.be = 4'b0011; b.wdata = '0;
    bus_q.push_back(b);
    ack_delay_next = 20;
    op_valid = 1'b1; op_we = 1'b0; op_type = 3'b011; op_addr = 32'h300; op_wdata = '0;
    $display("op reset-mid-busy lhu addr=%08h", op_addr);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("req_before_reset", {31'b0, bus_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("req_after_reset", {31'b0, bus_req}, 32'd0);
    chk("stall_after_reset", {31'b0, stall}, 32'd0);
    chk("ld_data_after_reset", ld_data, 32'd0);
    @(posedge clk); #1;

`ifdef DM_TIMEOUT_EN
    begin
      int busy_cnt;
      b.addr = 32'h3F0; b.we = 1'b0; b.be = 4'b1111; b.wdata = '0;
      bus_q.push_back(b);
      ack_delay_next = 1000;
      op_valid = 1'b1; op_we = 1'b0; op_type = 3'b111; op_addr = 32'h3F0;
      $display("op timeout lw addr=%08h", op_addr);
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus_err) break;
        if (bus_req) busy_cnt++;
      end
      chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
      chk("timeout_busy_cycles", busy_cnt, 32'd4);
      chk("timeout_ld_data", ld_data, 32'hdddd_dddd);
      chk("timeout_ld_valid", {31'b0, ld_valid}, 32'd0);
      chk("timeout_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk("timeout_pulse_end", {31'b0, bus_err}, 32'd0);
      @(posedge clk); #1;
    end
`endif

    // Randomized traffic with stray acks outside BUSY
    spurious_en = 1;
    for (int i = 0; i < 300; i++) begin
      fr = $urandom_range(0, 7);
      do_op(1'($urandom_range(0, 1)), pick_type($urandom_range(0, 10)),
            $urandom & 32'hC000_03FF, $urandom, $urandom_range(0, 3),
            (fr == 0) ? 1 : ((fr == 1) ? 2 : 0));
    end
    spurious_en = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
